// File: rtl/pong_ball_pkg.sv
// Shared pong ball constants and the ball FSM state encoding.
// No logic and no latency; imported by the ball engine and its serve counter.
package pong_ball_pkg;

  localparam int DEF_H_VISIBLE    = 400;
  localparam int DEF_V_VISIBLE    = 600;
  localparam int DEF_X_BITS       = 10;
  localparam int DEF_Y_BITS       = 10;
  localparam int DEF_BALL_RAD     = 4;
  localparam int DEF_SPEED_X      = 2;
  localparam int DEF_SPEED_Y      = 2;
  localparam int DEF_SERVE_FRAMES = 60;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_MOVE  = 2'd2,
    ST_GOAL  = 2'd3
  } state_t;

endpackage

// File: rtl/pong_ball_mod.sv
// Modulo-MOD event counter; o_tc flags the enable that completes a full count.
// o_tc is combinational on i_cen; count updates 1 clk later, no backpressure.
module pong_ball_mod #(
  parameter int MOD = 60
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cen,
  input  logic i_clr,
  output logic o_tc
);

  localparam int            CW     = (MOD > 1) ? $clog2(MOD) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(MOD - 1);

  logic [CW-1:0] r_count;

  assign o_tc = i_cen && (r_count == C_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_cen) begin
      r_count <= o_tc ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/pong_ball.sv
// Ball motion engine: per-frame move, wall/paddle bounces, goal detection and score pulses.
// Outputs update 1 clk after i_frame_tick; no backpressure, every frame tick is consumed.
module pong_ball
  import pong_ball_pkg::*;
#(
  parameter int H_VISIBLE    = DEF_H_VISIBLE,
  parameter int V_VISIBLE    = DEF_V_VISIBLE,
  parameter int X_BITS       = DEF_X_BITS,
  parameter int Y_BITS       = DEF_Y_BITS,
  parameter int BALL_RAD     = DEF_BALL_RAD,
  parameter int SPEED_X      = DEF_SPEED_X,
  parameter int SPEED_Y      = DEF_SPEED_Y,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_frame_tick,
  input  logic [X_BITS-1:0] i_p1_xmin,
  input  logic [X_BITS-1:0] i_p1_xmax,
  input  logic [Y_BITS-1:0] i_p1_ymin,
  input  logic [Y_BITS-1:0] i_p1_ymax,
  input  logic [X_BITS-1:0] i_p2_xmin,
  input  logic [X_BITS-1:0] i_p2_xmax,
  input  logic [Y_BITS-1:0] i_p2_ymin,
  input  logic [Y_BITS-1:0] i_p2_ymax,
  output logic [X_BITS-1:0] o_ball_x,
  output logic [Y_BITS-1:0] o_ball_y,
  output logic [X_BITS-1:0] o_ball_rad,
  output logic              o_score_left,
  output logic              o_score_right,
  output logic              o_busy
);

  localparam int XW = X_BITS + 2;
  localparam int YW = Y_BITS + 2;
  localparam logic signed [XW-1:0] C_RX     = XW'(BALL_RAD);
  localparam logic signed [XW-1:0] C_SX     = XW'(SPEED_X);
  localparam logic signed [XW-1:0] C_ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] C_ZERO_X = '0;
  localparam logic signed [XW-1:0] C_XEDGE  = XW'(H_VISIBLE - 1);
  localparam logic signed [YW-1:0] C_RY     = YW'(BALL_RAD);
  localparam logic signed [YW-1:0] C_SY     = YW'(SPEED_Y);
  localparam logic signed [YW-1:0] C_YBOT   = YW'(V_VISIBLE - 1 - BALL_RAD);
  localparam logic [X_BITS-1:0]    C_XMID   = X_BITS'(H_VISIBLE / 2);
  localparam logic [Y_BITS-1:0]    C_YMID   = Y_BITS'(V_VISIBLE / 2);

  state_t            r_state, w_state_nxt;
  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic              r_dx_neg, r_dy_neg;
  logic              r_score_left, r_score_right;

  logic signed [XW-1:0] w_x, w_nx, w_mx, w_p1_xmax, w_p2_xmin;
  logic signed [YW-1:0] w_y, w_ny, w_my, w_p1_ymin, w_p1_ymax, w_p2_ymin, w_p2_ymax;
  logic w_hit_l, w_hit_r, w_exit_l, w_exit_r, w_mdx_neg, w_mdy_neg;
  logic w_serve_done;

  // Hit tests only need the inner face of each paddle.
  logic w_unused_extents;
  assign w_unused_extents = ^{i_p1_xmin, i_p2_xmax};

  pong_ball_mod #(.MOD(SERVE_FRAMES)) u_serve_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_cen   (i_frame_tick && (r_state == ST_SERVE)),
    .i_clr   (!i_en || (r_state != ST_SERVE)),
    .o_tc    (w_serve_done)
  );

  // Collision and next-position; everything signed two bits wider so nothing wraps.
  always_comb begin
    w_x       = signed'({2'b00, r_x});
    w_y       = signed'({2'b00, r_y});
    w_p1_xmax = signed'({2'b00, i_p1_xmax});
    w_p2_xmin = signed'({2'b00, i_p2_xmin});
    w_p1_ymin = signed'({2'b00, i_p1_ymin});
    w_p1_ymax = signed'({2'b00, i_p1_ymax});
    w_p2_ymin = signed'({2'b00, i_p2_ymin});
    w_p2_ymax = signed'({2'b00, i_p2_ymax});
    w_nx      = r_dx_neg ? (w_x - C_SX) : (w_x + C_SX);
    w_ny      = r_dy_neg ? (w_y - C_SY) : (w_y + C_SY);

    w_hit_l  = r_dx_neg && (w_x - C_RX > w_p1_xmax) && (w_nx - C_RX <= w_p1_xmax) &&
               (w_y >= w_p1_ymin - C_RY) && (w_y <= w_p1_ymax + C_RY);
    w_hit_r  = !r_dx_neg && (w_x + C_RX < w_p2_xmin) && (w_nx + C_RX >= w_p2_xmin) &&
               (w_y >= w_p2_ymin - C_RY) && (w_y <= w_p2_ymax + C_RY);
    w_exit_l = r_dx_neg && !w_hit_l && (w_nx - C_RX <= C_ZERO_X);
    w_exit_r = !r_dx_neg && !w_hit_r && (w_nx + C_RX >= C_XEDGE);

    w_mx      = w_nx;
    w_mdx_neg = r_dx_neg;
    if (w_hit_l) begin
      w_mx      = w_p1_xmax + C_RX + C_ONE_X;
      w_mdx_neg = 1'b0;
    end else if (w_hit_r) begin
      w_mx      = w_p2_xmin - C_RX - C_ONE_X;
      w_mdx_neg = 1'b1;
    end

    w_my      = w_ny;
    w_mdy_neg = r_dy_neg;
    if (r_dy_neg && (w_ny <= C_RY)) begin
      w_my      = C_RY;
      w_mdy_neg = 1'b0;
    end else if (!r_dy_neg && (w_ny >= C_YBOT)) begin
      w_my      = C_YBOT;
      w_mdy_neg = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_SERVE;
        ST_SERVE: if (w_serve_done) w_state_nxt = ST_MOVE;
        ST_MOVE:  if (i_frame_tick && (w_exit_l || w_exit_r)) w_state_nxt = ST_GOAL;
        ST_GOAL:  w_state_nxt = ST_SERVE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Direction survives goals and en drops so the next serve heads at the conceding side.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_x           <= C_XMID;
      r_y           <= C_YMID;
      r_dx_neg      <= 1'b0;
      r_dy_neg      <= 1'b0;
      r_score_left  <= 1'b0;
      r_score_right <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_score_left  <= (w_state_nxt == ST_GOAL) && w_exit_r;
      r_score_right <= (w_state_nxt == ST_GOAL) && w_exit_l;
      if (!i_en || (r_state != ST_MOVE)) begin
        r_x <= C_XMID;
        r_y <= C_YMID;
      end else if (i_frame_tick) begin
        if (w_exit_l || w_exit_r) begin
          r_x <= C_XMID;
          r_y <= C_YMID;
        end else begin
          r_x      <= w_mx[X_BITS-1:0];
          r_y      <= w_my[Y_BITS-1:0];
          r_dx_neg <= w_mdx_neg;
          r_dy_neg <= w_mdy_neg;
        end
      end
    end
  end

  always_comb begin
    o_ball_x      = r_x;
    o_ball_y      = r_y;
    o_ball_rad    = X_BITS'(BALL_RAD);
    o_busy        = (r_state == ST_MOVE);
    o_score_left  = r_score_left;
    o_score_right = r_score_right;
  end

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: expected responses queued per frame tick, checked by a monitor.
module tb_pong_ball;

  logic       clk = 1'b0;
  logic       rst_n, en, frame_tick;
  logic [9:0] p1_xmin, p1_xmax, p1_ymin, p1_ymax;
  logic [9:0] p2_xmin, p2_xmax, p2_ymin, p2_ymax;
  logic [9:0] ball_x, ball_y, ball_rad;
  logic       score_left, score_right, busy;
  logic       tick_q = 1'b0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       busy;
    logic       sl;
    logic       sr;
  } resp_t;

  resp_t exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cnt_l = 0;
  int    cnt_r = 0;

  always #5 clk = ~clk;

  pong_ball dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_frame_tick  (frame_tick),
    .i_p1_xmin     (p1_xmin),
    .i_p1_xmax     (p1_xmax),
    .i_p1_ymin     (p1_ymin),
    .i_p1_ymax     (p1_ymax),
    .i_p2_xmin     (p2_xmin),
    .i_p2_xmax     (p2_xmax),
    .i_p2_ymin     (p2_ymin),
    .i_p2_ymax     (p2_ymax),
    .o_ball_x      (ball_x),
    .o_ball_y      (ball_y),
    .o_ball_rad    (ball_rad),
    .o_score_left  (score_left),
    .o_score_right (score_right),
    .o_busy        (busy)
  );

  // A response is due on the clock after every frame tick.
  always @(posedge clk) tick_q <= frame_tick;

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  initial begin : monitor
    resp_t act;
    resp_t e;
    string t;
    forever begin
      @(negedge clk);
      if (score_left === 1'b1) cnt_l++;
      if (score_right === 1'b1) cnt_r++;
      if (tick_q === 1'b1) begin
        n_vec++;
        act = {ball_x, ball_y, busy, score_left, score_right};
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty: got x=%0d y=%0d with no expected response", ball_x, ball_y);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d busy=%0b sl=%0b sr=%0b, want x=%0d y=%0d busy=%0b sl=%0b sr=%0b",
                     t, act.x, act.y, act.busy, act.sl, act.sr, e.x, e.y, e.busy, e.sl, e.sr);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not complete, %0d responses still queued", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input int ex, input int ey, input logic eb, input logic esl,
                          input logic esr, input string tag);
    resp_t e;
    e.x    = 10'(ex);
    e.y    = 10'(ey);
    e.busy = eb;
    e.sl   = esl;
    e.sr   = esr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick(input int ex, input int ey, input logic eb, input logic esl,
                      input logic esr, input string tag);
    push_exp(ex, ey, eb, esl, esr, tag);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve_phase(input string tag);
    for (int i = 1; i <= 60; i++) tick(200, 300, (i == 60), 1'b0, 1'b0, tag);
  endtask

  task automatic set_pads(input int a, input int b, input int c, input int d,
                          input int e, input int f, input int g, input int h);
    p1_xmin = 10'(a); p1_xmax = 10'(b); p1_ymin = 10'(c); p1_ymax = 10'(d);
    p2_xmin = 10'(e); p2_xmax = 10'(f); p2_ymin = 10'(g); p2_ymax = 10'(h);
  endtask

  // From centre heading down-right: right paddle at x=380 turns the ball at x=375.
  task automatic run_to_right_paddle(input string tag);
    for (int k = 1; k <= 88; k++)
      tick((k < 88) ? 200 + 2*k : 375, 300 + 2*k, 1'b1, 1'b0, 1'b0, tag);
  endtask

  // Down-left from (375,476) to the bottom wall; x_last differs when p1 also catches it.
  task automatic run_to_bottom(input int x_last, input string tag);
    for (int j = 1; j <= 60; j++)
      tick((j < 60) ? 375 - 2*j : x_last, (j < 60) ? 476 + 2*j : 595, 1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin : stim
    rst_n = 1'b0; en = 1'b0; frame_tick = 1'b0;
    set_pads(240, 252, 500, 599, 380, 390, 0, 599);
    repeat (3) @(negedge clk);
    chk("reset_x", ball_x, 200);
    chk("reset_y", ball_y, 300);
    chk("reset_rad", ball_rad, 4);
    chk("reset_busy", busy, 0);
    chk("reset_scores", {score_left, score_right}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    en = 1'b1;
    @(negedge clk);

    serve_phase("serve1");
    run_to_right_paddle("right_paddle_1");
    run_to_bottom(257, "wall_plus_p1_corner");

    // Right paddle moved out of the ball's path: exit on the right.
    set_pads(240, 252, 500, 599, 380, 390, 0, 100);
    for (int m = 1; m <= 68; m++) tick(257 + 2*m, 595 - 2*m, 1'b1, 1'b0, 1'b0, "to_right_goal");
    tick(200, 300, 1'b0, 1'b1, 1'b0, "right_goal");
    chk("left_pulses_1", cnt_l, 1);
    chk("right_pulses_1", cnt_r, 0);
    chk("pulse_cleared", score_left, 0);

    set_pads(10, 20, 200, 300, 380, 390, 0, 599);
    serve_phase("serve2");
    for (int k = 1; k <= 88; k++)
      tick((k < 88) ? 200 + 2*k : 375, 300 - 2*k, 1'b1, 1'b0, 1'b0, "right_paddle_2");
    for (int j = 1; j <= 60; j++)
      tick(375 - 2*j, (j < 60) ? 124 - 2*j : 4, 1'b1, 1'b0, 1'b0, "top_wall");
    for (int m = 1; m <= 116; m++)
      tick((m < 116) ? 255 - 2*m : 25, 4 + 2*m, 1'b1, 1'b0, 1'b0, "left_paddle");
    for (int n = 1; n <= 3; n++) tick(25 + 2*n, 236 + 2*n, 1'b1, 1'b0, 1'b0, "after_left_hit");

    en = 1'b0;
    @(negedge clk);
    chk("en_drop_x", ball_x, 200);
    chk("en_drop_y", ball_y, 300);
    chk("en_drop_busy", busy, 0);
    chk("en_drop_scores", {score_left, score_right}, 0);
    en = 1'b1;
    @(negedge clk);

    serve_phase("serve3");
    run_to_right_paddle("right_paddle_3");
    set_pads(10, 20, 0, 100, 380, 390, 0, 599);
    run_to_bottom(255, "bottom_wall");
    for (int m = 1; m <= 125; m++) tick(255 - 2*m, 595 - 2*m, 1'b1, 1'b0, 1'b0, "p1_miss");
    tick(200, 300, 1'b0, 1'b0, 1'b1, "left_goal");
    chk("right_pulses_2", cnt_r, 1);
    chk("left_pulses_2", cnt_l, 1);

    serve_phase("serve4");
    for (int k = 1; k <= 97; k++) tick(200 - 2*k, 300 - 2*k, 1'b1, 1'b0, 1'b0, "serve_left");
    push_exp(200, 300, 1'b0, 1'b0, 1'b1, "final_goal");
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("goal_reset_x", ball_x, 200);
    chk("goal_reset_y", ball_y, 300);
    chk("goal_reset_busy", busy, 0);
    chk("goal_reset_scores", {score_left, score_right}, 0);
    @(negedge clk);
    chk("right_pulses_3", cnt_r, 2);
    chk("left_pulses_3", cnt_l, 1);
    chk("queue_drained", exp_q.size(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
